chunked_serial_adder: RTL and testbench

Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in by processing CHUNK bits per clock, LSB chunk first, with a registered inter-chunk carry. It is the sequential, width-generalised successor of the team's small combinational adders. It trades latency for a CHUNK-bit-wide datapath and sits behind a start/busy/done handshake.

---
 rtl/adder_pkg.sv | 11 +
 rtl/chunked_serial_adder_if.sv | 14 +
 rtl/chunk_adder.sv | 12 +
 rtl/chunked_serial_adder.sv | 91 +++++++++
 tb/tb_chunked_serial_adder.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding for the sequential adder family
package adder_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;
endpackage

// File: rtl/chunked_serial_adder_if.sv
// chunked_serial_adder_if: start/busy/done handshake plus operand and result bus
//   master drives start, a, b, cin; slave drives busy, done, sum, cout
interface chunked_serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic             cin;
  logic             busy;
  logic             done;
  logic             cout;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  modport master(output start, a, b, cin, input busy, done, sum, cout);
  modport slave(input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit adder with carry in/out
//   a_i, b_i : CHUNK-bit addends, cin_i : carry in
//   sum_o    : CHUNK-bit sum,     cout_o: carry out
module chunk_adder #(parameter int CHUNK = 2) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
endmodule

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: WIDTH-bit a+b+cin computed CHUNK bits per clock, LSB chunk first
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of chunked_serial_adder_if (start/a/b/cin in, busy/done/sum/cout out)
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  chunked_serial_adder_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = $clog2(NCHUNK) + 1;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHUNK-1:0] csum;
  logic             ccout;
  logic             accept;
  logic             last;
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i   (a_q[CHUNK-1:0]),
    .b_i   (b_q[CHUNK-1:0]),
    .cin_i (carry_q),
    .sum_o (csum),
    .cout_o(ccout)
  );
  // DONE accepts a new start just like IDLE, giving back-to-back operation
  assign accept = bus.start && state_q != S_RUN;
  assign last = cnt_q == CW'(NCHUNK - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    carry_d = carry_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    cout_d = cout_q;
    if (state_q == S_RUN) begin
      // each chunk enters at the top so the first one ends at the bottom
      acc_d = (acc_q >> CHUNK) | (WIDTH'(csum) << (WIDTH - CHUNK));
      a_d = a_q >> CHUNK;
      b_d = b_q >> CHUNK;
      carry_d = ccout;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = S_DONE;
        sum_d = acc_d;
        cout_d = ccout;
      end
    end else if (accept) begin
      state_d = S_RUN;
      a_d = bus.a;
      b_d = bus.b;
      carry_d = bus.cin;
      cnt_d = '0;
      acc_d = '0;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      carry_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      carry_q <= carry_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
    end
  end
  assign bus.busy = state_q == S_RUN;
  assign bus.done = state_q == S_DONE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: scoreboard bench for CHUNK=2, CHUNK=1 and CHUNK=8 adders
module tb_chunked_serial_adder;
  typedef struct {
    logic [7:0] s;
    logic       c;
    int         due;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q2[$];
  exp_t q1[$];
  exp_t q8[$];
  chunked_serial_adder_if #(.WIDTH(8)) bus2();
  chunked_serial_adder_if #(.WIDTH(8)) bus1();
  chunked_serial_adder_if #(.WIDTH(8)) bus8();
  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut2(.clk(clk), .rst(rst), .bus(bus2.slave));
  chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) dut1(.clk(clk), .rst(rst), .bus(bus1.slave));
  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8(.clk(clk), .rst(rst), .bus(bus8.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic spurious(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected done got 1 want 0", nm);
  endtask
  task automatic chk(input string nm, input exp_t e, input logic [7:0] s, input logic c, input logic bsy);
    cmp({nm, " sum"}, 32'(s), 32'(e.s));
    cmp({nm, " cout"}, 32'(c), 32'(e.c));
    cmp({nm, " done cycle"}, cyc, e.due);
    cmp({nm, " busy at done"}, 32'(bsy), 0);
  endtask
  always @(negedge clk) if (bus2.done === 1'b1) begin
    if (q2.size() == 0) spurious("c2");
    else chk("c2", q2.pop_front(), bus2.sum, bus2.cout, bus2.busy);
  end
  always @(negedge clk) if (bus1.done === 1'b1) begin
    if (q1.size() == 0) spurious("c1");
    else chk("c1", q1.pop_front(), bus1.sum, bus1.cout, bus1.busy);
  end
  always @(negedge clk) if (bus8.done === 1'b1) begin
    if (q8.size() == 0) spurious("c8");
    else chk("c8", q8.pop_front(), bus8.sum, bus8.cout, bus8.busy);
  end
  task automatic issue2(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [7:0] es, input logic ec);
    bus2.a = a;
    bus2.b = b;
    bus2.cin = c;
    bus2.start = 1'b1;
    q2.push_back('{es, ec, cyc + 5});
  endtask
  task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [7:0] es, input logic ec);
    issue2(a, b, c, es, ec);
    @(negedge clk);
    bus2.start = 1'b0;
  endtask
  task automatic send_wide(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [7:0] es, input logic ec);
    bus1.a = a;
    bus1.b = b;
    bus1.cin = c;
    bus1.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    bus8.cin = c;
    bus8.start = 1'b1;
    q1.push_back('{es, ec, cyc + 9});
    q8.push_back('{es, ec, cyc + 2});
    @(negedge clk);
    bus1.start = 1'b0;
    bus8.start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (q2.size() == 0 && q1.size() == 0 && q8.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  initial begin
    bus2.start = 1'b1; bus2.a = 8'hFF; bus2.b = 8'h01; bus2.cin = 1'b1;
    bus1.start = 1'b1; bus1.a = 8'hFF; bus1.b = 8'h01; bus1.cin = 1'b1;
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset busy", 32'(bus2.busy), 0);
    cmp("reset done", 32'(bus2.done), 0);
    cmp("reset sum", 32'(bus2.sum), 0);
    cmp("reset cout", 32'(bus2.cout), 0);
    cmp("c1 reset outputs", 32'({bus1.busy, bus1.done, bus1.cout, bus1.sum}), 0);
    cmp("c8 reset outputs", 32'({bus8.busy, bus8.done, bus8.cout, bus8.sum}), 0);
    bus2.start = 1'b0;
    bus1.start = 1'b0;
    bus8.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    send2(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    drain();
    send2(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    drain();
    send2(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    drain();
    issue2(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    @(negedge clk);
    cmp("busy mid-run", 32'(bus2.busy), 1);
    bus2.a = 8'hAA;
    bus2.b = 8'h55;
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    issue2(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    bus2.start = 1'b0;
    drain();
    bus2.a = 8'h77;
    bus2.b = 8'h11;
    bus2.cin = 1'b0;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("async rst busy", 32'(bus2.busy), 0);
    cmp("async rst done", 32'(bus2.done), 0);
    cmp("async rst sum", 32'(bus2.sum), 0);
    cmp("async rst cout", 32'(bus2.cout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    send2(8'h03, 8'h05, 1'b1, 8'h09, 1'b0);
    drain();
    send_wide(8'hC3, 8'h3D, 1'b0, 8'h00, 1'b1);
    drain();
    send_wide(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    cmp("pending results", q2.size() + q1.size() + q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
